// File: rtl/morse_symbol_decoder_if.sv
// Keyer-side and consumer-side signals of the Morse symbol decoder.
// The decoder takes the slave view and the driving environment takes the master view.
interface morse_symbol_decoder_if #(
    parameter int MAX_SYM = 6
);
    logic               key_in;
    logic               out_valid;
    logic               out_ready;
    logic [2:0]         out_len;
    logic [MAX_SYM-1:0] out_pattern;
    logic               out_err;
    logic               overflow;
    logic               busy;

    modport master (
        output key_in, out_ready,
        input  out_valid, out_len, out_pattern, out_err, overflow, busy
    );

    modport slave (
        input  key_in, out_ready,
        output out_valid, out_len, out_pattern, out_err, overflow, busy
    );
endinterface

// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder.
// Times key marks and spaces in units of TICK_DIV cycles, classifies each mark
// as a dit or a dash, and groups the symbols into letters. Completed letters and
// word-space markers are queued in a small first-word-fall-through FIFO.
module morse_symbol_decoder #(
    parameter int TICK_DIV   = 1,
    parameter int DIT_MAX    = 7,
    parameter int GLITCH     = 1,
    parameter int LETTER_GAP = 15,
    parameter int WORD_GAP   = 40,
    parameter int MAX_SYM    = 6,
    parameter int FIFO_DEPTH = 4
) (
    input logic                   clk,
    input logic                   rst,
    morse_symbol_decoder_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MARK  = 2'd1;
    localparam logic [1:0] S_SPACE = 2'd2;

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [15:0]   GLITCH_U = 16'(GLITCH);
    localparam logic [15:0]   DIT_U    = 16'(DIT_MAX);
    localparam logic [15:0]   LG_U     = 16'(LETTER_GAP);
    localparam logic [15:0]   WG_U     = 16'(WORD_GAP);
    localparam logic [2:0]    LEN_MAX  = 3'(MAX_SYM);
    localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [2:0]         len;
        logic [MAX_SYM-1:0] pat;
        logic               err;
    } entry_t;

    logic [1:0]         r_state, w_state_nxt;
    logic               r_key_prev;
    logic [PW-1:0]      r_presc;
    logic [15:0]        r_dur, r_gap;
    logic [2:0]         r_len, w_len_nxt;
    logic [MAX_SYM-1:0] r_pat, w_pat_nxt;
    logic               r_err, w_err_nxt;
    entry_t             r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]      r_count;
    logic               r_ovf;

    logic        w_key, w_chg, w_tick, w_gap_clr, w_push, w_pop, w_full, w_wr, w_valid;
    logic [15:0] w_dur_eff, w_gap_eff;
    entry_t      w_push_ent, w_head;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    assign w_key  = bus.key_in;
    assign w_chg  = w_key ^ r_key_prev;
    assign w_tick = (r_presc == PRE_LAST);
    // Counts as they stand including this cycle's tick; decisions use these so
    // an N-cycle mark reads as N at its falling edge.
    assign w_dur_eff = (w_tick && r_dur != 16'hFFFF) ? r_dur + 16'd1 : r_dur;
    assign w_gap_eff = (w_tick && r_gap != 16'hFFFF) ? r_gap + 16'd1 : r_gap;

    // Previous key level, used to spot level changes
    always_ff @(posedge clk) begin
        if (rst) r_key_prev <= 1'b0;
        else     r_key_prev <= w_key;
    end

    // Unit prescaler, restarted on every key edge and while idle
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || w_chg || w_tick) r_presc <= '0;
        else                                            r_presc <= r_presc + PW'(1);
    end

    // Length of the current key level, in units
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || w_chg) r_dur <= '0;
        else                                   r_dur <= w_dur_eff;
    end

    // Units since the last accepted mark; keeps running through discarded glitches
    always_ff @(posedge clk) begin
        if (rst || r_state == S_IDLE || w_gap_clr) r_gap <= '0;
        else                                       r_gap <= w_gap_eff;
    end

    // Symbol classification, letter assembly and gap decisions
    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_pat_nxt   = r_pat;
        w_err_nxt   = r_err;
        w_gap_clr   = 1'b0;
        w_push      = 1'b0;
        w_push_ent  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_key) w_state_nxt = S_MARK;
            end
            S_MARK: begin
                if (!w_key) begin
                    if (w_dur_eff < GLITCH_U) begin
                        w_state_nxt = (r_len == 3'd0) ? S_IDLE : S_SPACE;
                    end else begin
                        w_state_nxt = S_SPACE;
                        w_gap_clr   = 1'b1;
                        if (r_len == LEN_MAX) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            for (int i = 0; i < MAX_SYM; i++)
                                if (r_len == 3'(i)) w_pat_nxt[i] = (w_dur_eff > DIT_U);
                            w_len_nxt = r_len + 3'd1;
                        end
                    end
                end
            end
            S_SPACE: begin
                if (w_key) begin
                    w_state_nxt = S_MARK;
                end else if (w_gap_eff >= LG_U && r_len != 3'd0) begin
                    w_push     = 1'b1;
                    w_push_ent = {r_len, r_pat, r_err};
                    w_len_nxt  = 3'd0;
                    w_pat_nxt  = '0;
                    w_err_nxt  = 1'b0;
                end else if (w_gap_eff >= WG_U) begin
                    w_push      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM and letter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_len   <= 3'd0;
            r_pat   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len   <= w_len_nxt;
            r_pat   <= w_pat_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // A pop frees a slot in the same cycle, so a push into a full FIFO that is
    // being drained still lands.
    assign w_valid = (r_count != '0);
    assign w_pop   = w_valid && bus.out_ready;
    assign w_full  = (r_count == CNT_FULL);
    assign w_wr    = w_push && (!w_full || w_pop);

    // Entry storage; outputs are gated by valid so no reset is needed here
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= w_push_ent;
    end

    // Pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (w_push && !w_wr) r_ovf <= 1'b1;
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign bus.out_valid   = w_valid;
    assign bus.out_len     = w_valid ? w_head.len : 3'd0;
    assign bus.out_pattern = w_valid ? w_head.pat : '0;
    assign bus.out_err     = w_valid ? w_head.err : 1'b0;
    assign bus.overflow    = r_ovf;
    assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: doc/morse_symbol_decoder.md
MORSE_SYMBOL_DECODER -- requirements
Module: morse_symbol_decoder

Interface
REQ-001 Parameter TICK_DIV, default 1: clock cycles per timing unit, range 1..65535.
REQ-002 Parameter DIT_MAX, default 7: longest mark in units still classified as a dit.
REQ-003 Parameter GLITCH, default 1: marks shorter than this many units are discarded.
REQ-004 Parameter LETTER_GAP, default 15: space in units that closes a letter.
REQ-005 Parameter WORD_GAP, default 40: space in units that emits a word-space entry (WORD_GAP > LETTER_GAP).
REQ-006 Parameter MAX_SYM, default 6: symbols per letter, range 1..7.
REQ-007 Parameter FIFO_DEPTH, default 4: output entries, power of 2.
REQ-008 Signal clk, input, width 1: the single clock; all logic on its rising edge.
REQ-009 Signal rst, input, width 1: synchronous, active-high reset.
REQ-010 Signal key_in, input, width 1: key level, already synchronised and debounced; 1 = key down.
REQ-011 Signal out_valid, output, width 1: head FIFO entry present.
REQ-012 Signal out_ready, input, width 1: consumer accepts head entry.
REQ-013 Signal out_len, output, width 3: symbol count of head entry; 0 = word space.
REQ-014 Signal out_pattern, output, width MAX_SYM: bit i = symbol i in send order; 1 = dash, 0 = dit; unused bits 0.
REQ-015 Signal out_err, output, width 1: head letter exceeded MAX_SYM symbols.
REQ-016 Signal overflow, output, width 1: sticky; an entry was dropped because the FIFO was full.
REQ-017 Signal busy, output, width 1: FSM is not in IDLE.

Function
REQ-018 Prescaler: counts 0..TICK_DIV-1 and pulses tick on wrap; it clears on every key_in level change and in IDLE.
REQ-019 Duration counter: 16 bits, cleared on key_in level change, increments on tick, saturates at all-ones; no wrap.
REQ-020 FSM has three states: IDLE, MARK and SPACE.
REQ-021 IDLE: key_in=1 -> MARK with dur=0; otherwise stay.
REQ-022 MARK, key_in falls: dur<GLITCH -> discard the mark, go to SPACE (or IDLE if len=0), and keep the gap count running as if the mark never occurred.
REQ-023 MARK, key_in falls, valid mark: dit if dur<=DIT_MAX, else dash; write to pattern[len], len+1, then SPACE with gap=0.
REQ-024 Valid mark with len already MAX_SYM: pattern and len unchanged; set err for the current letter.
REQ-025 SPACE, key_in=1: -> MARK (same letter).
REQ-026 SPACE, gap reaches LETTER_GAP with len>0: push {len, pattern, err}; clear len, pattern and err; stay in SPACE.
REQ-027 SPACE, gap reaches WORD_GAP: push {len=0, pattern=0, err=0}, then IDLE.
REQ-028 Latency: out_valid rises the cycle after the push cycle when the FIFO was empty.
REQ-029 FIFO is first-word-fall-through: out_* reflect the head whenever out_valid=1, and hold stable until popped.
REQ-030 Pop occurs on out_valid & out_ready.
REQ-031 Push while full with no pop: the entry is dropped and overflow is set to 1 until rst.
REQ-032 Push and pop in the same cycle while full: both succeed, no drop.
REQ-033 Push and pop in the same cycle while empty: the entry is pushed and valid the next cycle; no pop occurs.
REQ-034 Pointers wrap modulo FIFO_DEPTH; occupancy counter width is log2(FIFO_DEPTH)+1.
REQ-035 With TICK_DIV=1, a mark of N cycles high gives dur=N at the falling edge; a space of M cycles gives gap=M.

Reset
REQ-036 When rst=1 at a clock edge: FSM -> IDLE, and all counters, len, pattern, err, FIFO pointers and occupancy -> 0.
REQ-037 Reset values: out_valid=0, out_len=0, out_pattern=0, out_err=0, overflow=0, busy=0.
REQ-038 Reset mid-letter or mid-mark discards the partial letter; nothing is pushed.
REQ-039 key_in held high through reset release: enter MARK on the first post-reset cycle with dur=0.

Verification (defaults, TICK_DIV=1, out_ready=1 unless noted)
REQ-040 4x (6 cycles high, 2 low), then 20 low -> one entry: len=4, pattern=000000, err=0 ("H").
REQ-041 8 high, then 20 low -> len=1, pattern=000001 ("T"); 6 high, then 20 low -> len=1, pattern=000000 ("E").
REQ-042 "T", then 45 low total -> letter entry followed by word-space entry len=0; busy=0 afterwards.
REQ-043 out_ready=0, five "E" letters sent -> 4 entries queued, overflow=1; raise out_ready -> exactly 4 pops, in order.
REQ-044 7 dits, then gap -> len=6, pattern=000000, err=1; a 1-cycle glitch with GLITCH=2 leaves len unchanged.
REQ-045 rst pulsed after 3 dits, then 20 low -> no entry; all outputs at reset values.
